// File: rtl/menu_ctrl_gen.sv
// rtl/menu_ctrl_gen.sv - front-panel menu navigation and BCD config editor
// Decodes active-low buttons (with up/dn auto-repeat) and edits a shadow value committed on exit.
module menu_ctrl_gen #(
  parameter int N_CONF       = 5,
  parameter int DIGITS       = 6,
  parameter int CARRY        = 0,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  localparam int CI_W = (N_CONF > 1) ? $clog2(N_CONF) : 1,
  localparam int MI_W = $clog2(N_CONF + 1),
  localparam int VW   = DIGITS * 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            btn_up,
  input  logic            btn_dn,
  input  logic            btn_lf,
  input  logic            btn_rt,
  output logic [CI_W-1:0] conf_index,
  input  logic [VW-1:0]   conf_value,
  output logic [VW-1:0]   conf_new_value,
  output logic            conf_set,
  output logic [MI_W-1:0] menu_index,
  output logic [DIGITS-1:0] cursor,
  output logic [1:0]      display_mode,
  output logic            enable_morse
);

  localparam int RC_W = $clog2(REPEAT_DELAY + 1);

  typedef enum logic [1:0] {S_MENU, S_LOAD, S_EDIT, S_MORSE} state_t;

  state_t            state_q, state_d;
  logic [MI_W-1:0]   menu_q, menu_d;
  logic [CI_W-1:0]   conf_idx_q, conf_idx_d;
  logic [VW-1:0]     shadow_q, shadow_d;
  logic [VW-1:0]     copy_q, copy_d;
  logic [DIGITS-1:0] cursor_q, cursor_d;
  logic              set_q, set_d;
  logic [1:0]        mode_q, mode_d;
  logic              morse_q, morse_d;
  logic [3:0]        btn_q, btn_d;
  logic [RC_W-1:0]   rep_up_q, rep_up_d;
  logic [RC_W-1:0]   rep_dn_q, rep_dn_d;

  logic [RC_W-1:0]   up_cnt_nxt, dn_cnt_nxt;
  logic              ev_lf, ev_rt, ev_up, ev_dn;
  logic              act_lf, act_rt, act_up, act_dn;

  // Counter holds ticks since press; at REPEAT_DELAY it fires and rewinds by REPEAT_RATE.
  function automatic logic [RC_W:0] repeat_step(input logic prev, input logic now,
                                                 input logic [RC_W-1:0] cnt);
    if (now)
      return '0;
    else if (prev)
      return {1'b1, RC_W'(1)};
    else if (cnt == RC_W'(REPEAT_DELAY))
      return {1'b1, RC_W'(REPEAT_DELAY - REPEAT_RATE + 1)};
    else
      return {1'b0, cnt + RC_W'(1)};
  endfunction

  function automatic logic [VW-1:0] clamp_bcd(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  // Digits below the cursor see no carry; CARRY=0 keeps the chain cut at the cursor digit.
  function automatic logic [VW-1:0] bcd_step(input logic [VW-1:0] v,
                                             input logic [DIGITS-1:0] cur, input logic up);
    logic [VW-1:0] r;
    logic          c;
    logic          a;
    logic          co;
    logic [4:0]    t;
    r = v;
    c = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      a = cur[i] | c;
      if (up) begin
        t  = {1'b0, v[4*i +: 4]} + {4'd0, a};
        co = (t > 5'd9);
        if (co) t = t - 5'd10;
      end else begin
        t  = {1'b0, v[4*i +: 4]} + 5'd10 - {4'd0, a};
        co = (t < 5'd10);
        if (!co) t = t - 5'd10;
      end
      r[4*i +: 4] = t[3:0];
      c = (CARRY != 0) && co;
    end
    return r;
  endfunction

  assign ev_lf = btn_q[3] & ~btn_lf;
  assign ev_rt = btn_q[2] & ~btn_rt;
  assign {ev_up, up_cnt_nxt} = repeat_step(btn_q[1], btn_up, rep_up_q);
  assign {ev_dn, dn_cnt_nxt} = repeat_step(btn_q[0], btn_dn, rep_dn_q);

  assign act_lf = ev_lf;
  assign act_rt = ev_rt & ~ev_lf;
  assign act_up = ev_up & ~ev_lf & ~ev_rt;
  assign act_dn = ev_dn & ~ev_lf & ~ev_rt & ~ev_up;

  always_comb begin
    state_d    = state_q;
    menu_d     = menu_q;
    conf_idx_d = conf_idx_q;
    shadow_d   = shadow_q;
    copy_d     = copy_q;
    cursor_d   = cursor_q;
    set_d      = 1'b0;
    mode_d     = mode_q;
    morse_d    = morse_q;
    btn_d      = btn_q;
    rep_up_d   = rep_up_q;
    rep_dn_d   = rep_dn_q;
    if (ce) begin
      btn_d    = {btn_lf, btn_rt, btn_up, btn_dn};
      rep_up_d = up_cnt_nxt;
      rep_dn_d = dn_cnt_nxt;
      case (state_q)
        S_MENU: begin
          if (act_rt) begin
            if (menu_q == '0) begin
              state_d = S_MORSE;
            end else begin
              conf_idx_d = CI_W'(menu_q - MI_W'(1));
              state_d    = S_LOAD;
            end
          end else if (act_up) begin
            menu_d = (menu_q == '0) ? MI_W'(N_CONF) : menu_q - MI_W'(1);
          end else if (act_dn) begin
            menu_d = (menu_q == MI_W'(N_CONF)) ? '0 : menu_q + MI_W'(1);
          end
        end
        S_LOAD: begin
          shadow_d = clamp_bcd(conf_value);
          copy_d   = clamp_bcd(conf_value);
          cursor_d = DIGITS'(1);
          state_d  = S_EDIT;
        end
        S_EDIT: begin
          if (act_lf) begin
            state_d = S_MENU;
            set_d   = (shadow_q != copy_q);
          end else if (act_rt) begin
            cursor_d = {cursor_q[DIGITS-2:0], cursor_q[DIGITS-1]};
          end else if (act_up) begin
            shadow_d = bcd_step(shadow_q, cursor_q, 1'b1);
          end else if (act_dn) begin
            shadow_d = bcd_step(shadow_q, cursor_q, 1'b0);
          end
        end
        S_MORSE: begin
          if (act_lf) state_d = S_MENU;
        end
        default: state_d = S_MENU;
      endcase
      mode_d  = (state_d == S_MORSE) ? 2'd2 :
                (state_d == S_MENU)  ? 2'd0 : 2'd1;
      morse_d = (state_d == S_MORSE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_MENU;
      menu_q     <= '0;
      conf_idx_q <= '0;
      shadow_q   <= '0;
      copy_q     <= '0;
      cursor_q   <= DIGITS'(1);
      set_q      <= 1'b0;
      mode_q     <= 2'd0;
      morse_q    <= 1'b0;
      btn_q      <= '1;
      rep_up_q   <= '0;
      rep_dn_q   <= '0;
    end else begin
      state_q    <= state_d;
      menu_q     <= menu_d;
      conf_idx_q <= conf_idx_d;
      shadow_q   <= shadow_d;
      copy_q     <= copy_d;
      cursor_q   <= cursor_d;
      set_q      <= set_d;
      mode_q     <= mode_d;
      morse_q    <= morse_d;
      btn_q      <= btn_d;
      rep_up_q   <= rep_up_d;
      rep_dn_q   <= rep_dn_d;
    end
  end

  assign conf_index     = conf_idx_q;
  assign conf_new_value = shadow_q;
  assign conf_set       = set_q;
  assign menu_index     = menu_q;
  assign cursor         = cursor_q;
  assign display_mode   = mode_q;
  assign enable_morse   = morse_q;

endmodule
